// File: rtl/output_deskew_pkg.sv
// Shared defaults and helpers for the output deskew block.
package output_deskew_pkg;

  localparam int def_data_width = 14;
  localparam int def_lanes      = 8;
  localparam int def_frame_len  = 256;

  // Bits needed to index v distinct values. Never returns less than 1,
  // so a degenerate frame_len of 1 still gets a legal vector width.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // LSB position of lane k in a packed multi-lane bus.
  function automatic int lane_lsb(input int k, input int width);
    return k * width;
  endfunction

endpackage

// File: rtl/output_deskew_if.sv
// Bus between the multiplier array output and the write-back stage.
// The deskew block sits on the slave modport; the array/write-back side
// (or a bench standing in for it) uses master.
interface output_deskew_if
  import output_deskew_pkg::*;
#(
  parameter int data_width = def_data_width,
  parameter int lanes      = def_lanes,
  parameter int frame_len  = def_frame_len
) ();

  localparam int idx_w = clog2(frame_len);

  logic                          flush;
  logic                          in_valid;
  logic [lanes*data_width-1:0]   din;
  logic                          out_valid;
  logic [lanes*data_width-1:0]   dout;
  logic                          out_last;
  logic [idx_w-1:0]              beat_idx;
  logic                          skew_err;

  modport master (
    output flush, in_valid, din,
    input  out_valid, dout, out_last, beat_idx, skew_err
  );

  modport slave (
    input  flush, in_valid, din,
    output out_valid, dout, out_last, beat_idx, skew_err
  );

endinterface

// File: rtl/output_deskew_lane_delay.sv
// Fixed-depth register chain with synchronous flush. Used once per data
// lane (depth lanes-k) and once, 1 bit wide, for the valid pipeline.
module output_deskew_lane_delay #(
  parameter int width = 14,
  parameter int depth = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_q
);

  logic [depth-1:0][width-1:0] r_pipe;

  // Shift the chain by one stage per clock; flush empties it.
  // NOTE: the chain is ordinary flops, not a memory, so it takes the async
  // reset like any other state and never powers up holding stale lanes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else if (i_flush) begin
      r_pipe <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures its neighbour's old value;
      // blocking here would collapse the whole chain into one cycle.
      r_pipe[0] <= i_d;
      for (int i = 1; i < depth; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[depth-1];

endmodule

// File: rtl/output_deskew.sv
// Removes the lane stagger produced by the polynomial-multiplier array:
// lane k of a beat arrives k cycles after lane 0, and every lane is delayed
// by lanes-k so the whole beat appears together lanes cycles after in_valid.
// Also tracks frame position and flags in_valid patterns that would let a
// beat overlap the next frame's alignment window.
module output_deskew
  import output_deskew_pkg::*;
#(
  parameter int data_width = def_data_width,
  parameter int lanes      = def_lanes,
  parameter int frame_len  = def_frame_len
) (
  input  logic           clk,
  input  logic           rst_n,
  output_deskew_if.slave bus
);

  localparam int idx_w = clog2(frame_len);
  localparam int cnt_w = clog2(lanes + 1);

  logic [lanes*data_width-1:0] w_dout;
  logic                        w_out_valid;
  logic [lanes-1:0]            r_hist;
  logic [idx_w-1:0]            r_beat_idx;
  logic                        r_skew_err;
  logic [cnt_w-1:0]            w_inflight;
  logic                        w_skew_hit;

  // Per-lane alignment: lane k already lags lane 0 by k cycles, so it only
  // needs the remaining lanes-k stages to land on the common output cycle.
  for (genvar k = 0; k < lanes; k++) begin : g_lane
    output_deskew_lane_delay #(
      .width (data_width),
      .depth (lanes - k)
    ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (bus.flush),
      .i_d     (bus.din[lane_lsb(k, data_width) +: data_width]),
      .o_q     (w_dout[lane_lsb(k, data_width) +: data_width])
    );
  end

  // Valid travels alongside lane 0, so its last stage lines up with dout.
  output_deskew_lane_delay #(
    .width (1),
    .depth (lanes)
  ) u_valid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (bus.flush),
    .i_d     (bus.in_valid),
    .o_q     (w_out_valid)
  );

  // History of recent in_valid cycles: the beats still inside the pipeline,
  // including the one on dout this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist <= '0;
    end else if (bus.flush) begin
      r_hist <= '0;
    end else begin
      r_hist <= {r_hist[lanes-2:0], bus.in_valid};
    end
  end

  // Count in-flight beats and decide whether a new beat breaks the frame
  // alignment window near the end of a frame.
  always_comb begin
    int v_idx;
    int v_inflight;
    // NOTE: every output gets a default before any conditional logic, so no
    // path through the block leaves a value held (which would infer a latch).
    w_inflight = '0;
    w_skew_hit = 1'b0;
    for (int i = 0; i < lanes; i++) begin
      w_inflight = w_inflight + cnt_w'(r_hist[i]);
    end
    v_idx      = int'(r_beat_idx);
    v_inflight = int'(w_inflight);
    if (bus.in_valid && !bus.flush
        && ((frame_len - v_idx) < lanes)
        && ((v_idx + v_inflight) > frame_len)) begin
      w_skew_hit = 1'b1;
    end
  end

  // Frame position of the beat on dout; advances once per emitted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat_idx <= '0;
    end else if (bus.flush) begin
      r_beat_idx <= '0;
    end else if (w_out_valid) begin
      if (r_beat_idx == idx_w'(frame_len - 1)) begin
        r_beat_idx <= '0;
      end else begin
        r_beat_idx <= r_beat_idx + 1'b1;
      end
    end
  end

  // Sticky timing-contract violation; only reset or flush clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skew_err <= 1'b0;
    end else if (bus.flush) begin
      r_skew_err <= 1'b0;
    end else if (w_skew_hit) begin
      r_skew_err <= 1'b1;
    end
  end

  // dout is deliberately ungated; consumers qualify it with out_valid.
  assign bus.dout      = w_dout;
  assign bus.out_valid = w_out_valid;
  assign bus.beat_idx  = r_beat_idx;
  assign bus.out_last  = w_out_valid && (r_beat_idx == idx_w'(frame_len - 1));
  assign bus.skew_err  = r_skew_err;

endmodule

// File: tb/tb_output_deskew.sv
// Directed bench for output_deskew with lanes=4, data_width=14, frame_len=8.
// Cycle numbers in the expectations are relative to the start of each
// play() call; a beat with in_valid in cycle t is expected on dout in t+4.
module tb_output_deskew;

  localparam int dw = 14;
  localparam int ln = 4;
  localparam int fl = 8;

  logic clk;
  logic rst_n;

  output_deskew_if #(.data_width(dw), .lanes(ln), .frame_len(fl)) bus ();

  output_deskew #(
    .data_width (dw),
    .lanes      (ln),
    .frame_len  (fl)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic              obs_v [32];
  logic [ln*dw-1:0]  obs_d [32];
  logic [2:0]        obs_i [32];
  logic              obs_l [32];
  logic              obs_s [32];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ln*dw-1:0] pack4(input int l0, input int l1, input int l2, input int l3);
    return {14'(l3), 14'(l2), 14'(l1), 14'(l0)};
  endfunction

  // Drive one cycle of staggered input: lane k carries the beat that started
  // k cycles ago. Beat ordinal b (count of earlier starts) has lane k = base+b*16+k.
  task automatic drive_cycle(input logic [31:0] vmask, input logic [31:0] fmask,
                             input int base, input int c);
    bus.in_valid = vmask[c];
    bus.flush    = fmask[c];
    bus.din      = '0;
    for (int k = 0; k < ln; k++) begin
      int s;
      int ord;
      s = c - k;
      if (s >= 0 && vmask[s]) begin
        ord = 0;
        for (int j = 0; j < s; j++) ord += int'(vmask[j]);
        bus.din[k*dw +: dw] = 14'(base + ord*16 + k);
      end
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic play(input logic [31:0] vmask, input logic [31:0] fmask,
                      input int base, input int n);
    for (int c = 0; c < n; c++) begin
      drive_cycle(vmask, fmask, base, c);
      #1;
      obs_v[c] = bus.out_valid;
      obs_d[c] = bus.dout;
      obs_i[c] = bus.beat_idx;
      obs_l[c] = bus.out_last;
      obs_s[c] = bus.skew_err;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.din      = '0;
  endtask

  task automatic do_flush();
    bus.in_valid = 1'b0;
    bus.din      = '0;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    bus.din      = {ln{14'h3FFF}};
    rst_n        = 1'b1;
    #1 rst_n     = 1'b0;

    // Reset held for three cycles with all-ones lane data.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst_valid_%0d", i), 64'(bus.out_valid), 64'd0);
      check($sformatf("rst_dout_%0d", i),  64'(bus.dout),      64'd0);
      check($sformatf("rst_idx_%0d", i),   64'(bus.beat_idx),  64'd0);
      check($sformatf("rst_skew_%0d", i),  64'(bus.skew_err),  64'd0);
      check($sformatf("rst_last_%0d", i),  64'(bus.out_last),  64'd0);
    end
    #3 rst_n = 1'b1;
    bus.din = '0;
    @(posedge clk); #1;
    check("idle_valid", 64'(bus.out_valid), 64'd0);

    // Single beat, lanes 1..4.
    play(32'h1, 32'h0, 1, 8);
    check("single_v3",   64'(obs_v[3]), 64'd0);
    check("single_v4",   64'(obs_v[4]), 64'd1);
    check("single_d4",   64'(obs_d[4]), 64'(pack4(1, 2, 3, 4)));
    check("single_i4",   64'(obs_i[4]), 64'd0);
    check("single_l4",   64'(obs_l[4]), 64'd0);
    check("single_v5",   64'(obs_v[5]), 64'd0);
    check("single_i5",   64'(obs_i[5]), 64'd1);

    // Full frame, eight back-to-back beats.
    do_flush();
    play(32'hFF, 32'h0, 0, 14);
    check("ff_v3", 64'(obs_v[3]), 64'd0);
    for (int b = 0; b < 8; b++) begin
      check($sformatf("ff_v_%0d", b), 64'(obs_v[b+4]), 64'd1);
      check($sformatf("ff_i_%0d", b), 64'(obs_i[b+4]), 64'(b));
      check($sformatf("ff_d_%0d", b), 64'(obs_d[b+4]),
            64'(pack4(b*16, b*16+1, b*16+2, b*16+3)));
      check($sformatf("ff_l_%0d", b), 64'(obs_l[b+4]), (b == 7) ? 64'd1 : 64'd0);
    end
    check("ff_v12",    64'(obs_v[12]), 64'd0);
    check("ff_i12",    64'(obs_i[12]), 64'd0);
    check("ff_skew13", 64'(obs_s[13]), 64'd0);

    // Bubbles: in_valid at 0,1,3,6 -> out_valid at 4,5,7,10.
    do_flush();
    play(32'h4B, 32'h0, 0, 13);
    check("bub_v4",  64'(obs_v[4]),  64'd1);
    check("bub_v5",  64'(obs_v[5]),  64'd1);
    check("bub_v6",  64'(obs_v[6]),  64'd0);
    check("bub_v7",  64'(obs_v[7]),  64'd1);
    check("bub_v8",  64'(obs_v[8]),  64'd0);
    check("bub_v9",  64'(obs_v[9]),  64'd0);
    check("bub_v10", 64'(obs_v[10]), 64'd1);
    check("bub_d4",  64'(obs_d[4]),  64'(pack4(0, 1, 2, 3)));
    check("bub_d5",  64'(obs_d[5]),  64'(pack4(16, 17, 18, 19)));
    check("bub_d7",  64'(obs_d[7]),  64'(pack4(32, 33, 34, 35)));
    check("bub_d10", 64'(obs_d[10]), 64'(pack4(48, 49, 50, 51)));
    check("bub_i6",  64'(obs_i[6]),  64'd2);
    check("bub_i7",  64'(obs_i[7]),  64'd2);
    check("bub_i9",  64'(obs_i[9]),  64'd3);
    check("bub_i11", 64'(obs_i[11]), 64'd4);

    // Flush with three beats in flight (cycle 3), new beat at 6, then a
    // flush colliding with in_valid at 12 which must drop that beat.
    do_flush();
    play(32'h1047, 32'h1008, 0, 18);
    for (int c = 4; c < 10; c++) begin
      check($sformatf("fl_v%0d", c), 64'(obs_v[c]), 64'd0);
      check($sformatf("fl_i%0d", c), 64'(obs_i[c]), 64'd0);
    end
    check("fl_v10",  64'(obs_v[10]), 64'd1);
    check("fl_d10",  64'(obs_d[10]), 64'(pack4(48, 49, 50, 51)));
    check("fl_i10",  64'(obs_i[10]), 64'd0);
    check("fl_i11",  64'(obs_i[11]), 64'd1);
    check("fl_i13",  64'(obs_i[13]), 64'd0);
    check("fl_v16",  64'(obs_v[16]), 64'd0);

    // Nine back-to-back beats stay inside the contract.
    do_flush();
    play(32'h1FF, 32'h0, 0, 16);
    check("sk9_s10", 64'(obs_s[10]), 64'd0);
    check("sk9_s15", 64'(obs_s[15]), 64'd0);

    // The tenth consecutive beat arrives with beat_idx=5 and 4 in flight.
    do_flush();
    play(32'h3FF, 32'h0, 0, 16);
    check("sk10_s9",  64'(obs_s[9]),  64'd0);
    check("sk10_s10", 64'(obs_s[10]), 64'd1);
    check("sk10_s15", 64'(obs_s[15]), 64'd1);
    check("sk10_l11", 64'(obs_l[11]), 64'd1);
    check("sk10_v12", 64'(obs_v[12]), 64'd1);
    check("sk10_i12", 64'(obs_i[12]), 64'd0);
    check("sk10_d12", 64'(obs_d[12]), 64'(pack4(128, 129, 130, 131)));
    check("sk10_l12", 64'(obs_l[12]), 64'd0);
    do_flush();
    check("sk_flush_clr", 64'(bus.skew_err), 64'd0);

    // Async reset between edges while a frame is streaming.
    do_flush();
    for (int c = 0; c < 6; c++) begin
      drive_cycle(32'hFF, 32'h0, 0, c);
      @(posedge clk); #1;
    end
    check("ar_pre_v", 64'(bus.out_valid), 64'd1);
    check("ar_pre_i", 64'(bus.beat_idx),  64'd2);
    bus.in_valid = 1'b0;
    bus.din      = '0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_v", 64'(bus.out_valid), 64'd0);
    check("ar_d", 64'(bus.dout),      64'd0);
    check("ar_i", 64'(bus.beat_idx),  64'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    play(32'h3, 32'h0, 5, 8);
    check("rec_v3", 64'(obs_v[3]), 64'd0);
    check("rec_v4", 64'(obs_v[4]), 64'd1);
    check("rec_i4", 64'(obs_i[4]), 64'd0);
    check("rec_d4", 64'(obs_d[4]), 64'(pack4(5, 6, 7, 8)));
    check("rec_i5", 64'(obs_i[5]), 64'd1);
    check("rec_d5", 64'(obs_d[5]), 64'(pack4(21, 22, 23, 24)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
